// File: rtl/tdc_multi_capture.sv
// Multi-channel TDC capture core: a common start arms a coarse counter, and the first
// stop hit on each channel is tagged {ch, timeout, coarse, fine} and queued in a show-ahead FIFO.
module tdc_multi_capture #(
  parameter int N_CH       = 4,
  parameter int COARSE_W   = 12,
  parameter int FINE_W     = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_B      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int FINE_B    = $clog2(FINE_W + 1),
  localparam int REC_W     = CH_B + 1 + COARSE_W + FINE_B
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_CH-1:0]          stop_hit,
  input  logic [N_CH*FINE_W-1:0]   stop_therm,
  // Output handshake: a record transfers on every rising clk edge where
  // out_valid && out_ready; out_data is stable while out_valid is high and not popped.
  output logic [REC_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     fifo_full
);

  localparam int PTR_B = $clog2(FIFO_DEPTH);
  localparam int CNT_B = PTR_B + 1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = {COARSE_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FLUSH} state_t;

  state_t              state;
  logic [COARSE_W-1:0] coarse;
  logic [N_CH-1:0]     hit;
  logic [N_CH-1:0]     pending;
  logic [REC_W-1:0]    rec [N_CH];
  logic [FINE_B-1:0]   fine [N_CH];

  logic [REC_W-1:0]    mem [FIFO_DEPTH];
  logic [PTR_B-1:0]    rd_ptr;
  logic [PTR_B-1:0]    wr_ptr;
  logic [CNT_B-1:0]    count;

  logic [CH_B-1:0]     sel;
  logic                any_pending;
  logic                full;
  logic                push;
  logic                pop;
  logic [N_CH-1:0]     pend_clear;
  logic [N_CH-1:0]     new_hit;
  logic [N_CH-1:0]     hit_now;
  logic                timed_out;
  logic [N_CH-1:0]     to_bits;

  // Popcount rather than first-zero search, so bubbles in the tap vector cost at most one LSB.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      fine[i] = '0;
      for (int j = 0; j < FINE_W; j++) begin
        fine[i] = fine[i] + FINE_B'(stop_therm[i*FINE_W + j]);
      end
    end
  end

  always_comb begin
    sel         = '0;
    any_pending = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel         = CH_B'(i);
        any_pending = 1'b1;
      end
    end
  end

  assign full       = (count == CNT_B'(FIFO_DEPTH));
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign push       = any_pending && (state != S_IDLE) && !abort && (!full || pop);
  assign pend_clear = push ? (N_CH'(1) << sel) : '0;

  assign new_hit   = stop_hit & ~hit;
  assign hit_now   = hit | new_hit;
  assign timed_out = (coarse == COARSE_MAX);
  assign to_bits   = timed_out ? ~hit_now : '0;

  assign busy      = (state != S_IDLE);
  assign fifo_full = full;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      coarse  <= '0;
      hit     <= '0;
      pending <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= S_IDLE;
        hit     <= '0;
        pending <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_ARMED;
              coarse  <= '0;
              hit     <= '0;
              pending <= '0;
            end
          end
          S_ARMED: begin
            coarse  <= timed_out ? coarse : coarse + COARSE_W'(1);
            hit     <= hit_now | to_bits;
            pending <= (pending & ~pend_clear) | new_hit | to_bits;
            if ((&hit_now) || timed_out) state <= S_FLUSH;
          end
          S_FLUSH: begin
            pending <= pending & ~pend_clear;
            if (pending == '0) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Hits in the timeout cycle still record their real stamp; only channels left unhit time out.
  always_ff @(posedge clk) begin
    if (state == S_ARMED && !abort) begin
      for (int i = 0; i < N_CH; i++) begin
        if (new_hit[i]) rec[i] <= {CH_B'(i), 1'b0, coarse, fine[i]};
        else if (to_bits[i]) rec[i] <= {CH_B'(i), 1'b1, COARSE_MAX, FINE_B'(0)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec[sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_B'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_B'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_B'(1);
        2'b01:   count <= count - CNT_B'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_multi_capture.sv
// Directed bench for tdc_multi_capture: a default-size instance (main) and a small one
// (COARSE_W=4, FIFO_DEPTH=2) for the timeout and back-pressure cases.
module tb_tdc_multi_capture;

  logic clk;
  logic rst;

  logic        start, abort, out_ready;
  logic [3:0]  stop_hit;
  logic [63:0] stop_therm;
  logic [19:0] out_data;
  logic        out_valid, busy, done, fifo_full;

  logic        s_start, s_abort, s_out_ready;
  logic [3:0]  s_stop_hit;
  logic [63:0] s_stop_therm;
  logic [11:0] s_out_data;
  logic        s_out_valid, s_busy, s_done, s_fifo_full;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int s_done_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] s_exp_q[$];

  tdc_multi_capture dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stop_hit(stop_hit), .stop_therm(stop_therm),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .fifo_full(fifo_full)
  );

  tdc_multi_capture #(.N_CH(4), .COARSE_W(4), .FINE_W(16), .FIFO_DEPTH(2)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort),
    .stop_hit(s_stop_hit), .stop_therm(s_stop_therm),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .busy(s_busy), .done(s_done), .fifo_full(s_fifo_full)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (!rst && done)   done_cnt++;
    if (!rst && s_done) s_done_cnt++;
  end

  function automatic logic [31:0] mk(input int ch, input int to, input int co, input int fi);
    logic [1:0] c; logic t; logic [11:0] k; logic [4:0] f;
    c = ch[1:0]; t = to[0]; k = co[11:0]; f = fi[4:0];
    return {12'd0, c, t, k, f};
  endfunction

  function automatic logic [31:0] mks(input int ch, input int to, input int co, input int fi);
    logic [1:0] c; logic t; logic [3:0] k; logic [4:0] f;
    c = ch[1:0]; t = to[0]; k = co[3:0]; f = fi[4:0];
    return {20'd0, c, t, k, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_main(input string tag);
    int k;
    logic [31:0] e;
    k = 0;
    while (!out_valid && k < 100) begin tick(); k++; end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    e = exp_q.pop_front();
    chk(tag, {12'd0, out_data}, e);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic read_small(input string tag);
    int k;
    logic [31:0] e;
    k = 0;
    while (!s_out_valid && k < 100) begin tick(); k++; end
    chk({tag, "_valid"}, {31'd0, s_out_valid}, 32'd1);
    e = s_exp_q.pop_front();
    chk(tag, {20'd0, s_out_data}, e);
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
  endtask

  task automatic wait_idle_main(input string tag);
    int k;
    k = 0;
    while (busy && k < 200) begin tick(); k++; end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle_small(input string tag);
    int k;
    k = 0;
    while (s_busy && k < 200) begin tick(); k++; end
    chk(tag, {31'd0, s_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; abort = 0; out_ready = 0; stop_hit = '0; stop_therm = '0;
    s_start = 0; s_abort = 0; s_out_ready = 0; s_stop_hit = '0; s_stop_therm = '0;
    tick(3);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {12'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_s_valid", {31'd0, s_out_valid}, 32'd0);
    rst = 1'b0;
    tick(2);

    // Test 1: four hits at coarse 5, 9, 9, 20
    stop_therm = {4{16'h00FF}};
    start = 1; tick(); start = 0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    tick(5);
    stop_hit = 4'b0001; tick(); stop_hit = '0;
    tick(3);
    stop_hit = 4'b0110; tick(); stop_hit = '0;
    tick(10);
    stop_hit = 4'b1000; tick(); stop_hit = '0;
    exp_q.push_back(mk(0, 0, 5, 8));
    exp_q.push_back(mk(1, 0, 9, 8));
    exp_q.push_back(mk(2, 0, 9, 8));
    exp_q.push_back(mk(3, 0, 20, 8));
    for (int i = 0; i < 4; i++) read_main("t1_rec");
    wait_idle_main("t1_idle");
    tick();
    chk("t1_done_cnt", done_cnt, 32'd1);
    chk("t1_empty", {31'd0, out_valid}, 32'd0);

    // Test 2 (small): ch2 at c3, others time out at coarse 15
    s_stop_therm = 64'h0000_00FF_0000_0000;
    s_start = 1; tick(); s_start = 0;
    tick(3);
    s_stop_hit = 4'b0100; tick(); s_stop_hit = '0;
    s_exp_q.push_back(mks(2, 0, 3, 8));
    read_small("t2_hit");
    s_exp_q.push_back(mks(0, 1, 15, 0));
    s_exp_q.push_back(mks(1, 1, 15, 0));
    s_exp_q.push_back(mks(3, 1, 15, 0));
    for (int i = 0; i < 3; i++) read_small("t2_timeout");
    wait_idle_small("t2_idle");
    tick();
    chk("t2_done_cnt", s_done_cnt, 32'd1);

    // Test 3 (small): four same-cycle hits into a 2-deep FIFO with no reader
    s_stop_therm = {16'hFFFF, 16'h0007, 16'h0003, 16'h0001};
    s_start = 1; tick(); s_start = 0;
    tick(2);
    s_stop_hit = 4'b1111; tick(); s_stop_hit = '0;
    tick(4);
    chk("t3_full", {31'd0, s_fifo_full}, 32'd1);
    chk("t3_held_busy", {31'd0, s_busy}, 32'd1);
    chk("t3_done_not_yet", s_done_cnt, 32'd1);
    s_exp_q.push_back(mks(0, 0, 2, 1));
    s_exp_q.push_back(mks(1, 0, 2, 2));
    s_exp_q.push_back(mks(2, 0, 2, 3));
    s_exp_q.push_back(mks(3, 0, 2, 16));
    for (int i = 0; i < 4; i++) read_small("t3_rec");
    wait_idle_small("t3_idle");
    tick();
    chk("t3_done_cnt", s_done_cnt, 32'd2);
    chk("t3_empty", {31'd0, s_out_valid}, 32'd0);
    chk("t3_not_full", {31'd0, s_fifo_full}, 32'd0);

    // Test 4: bubbled taps on ch1, second ch1 hit ignored
    stop_therm = 64'h0000_0000_0F3F_0000;
    start = 1; tick(); start = 0;
    tick(2);
    stop_hit = 4'b0010; tick(); stop_hit = '0;
    tick();
    stop_therm = 64'h0000_0000_FFFF_0000;
    stop_hit = 4'b0010; tick(); stop_hit = '0;
    tick();
    stop_therm = '0;
    stop_hit = 4'b1101; tick(); stop_hit = '0;
    exp_q.push_back(mk(1, 0, 2, 10));
    exp_q.push_back(mk(0, 0, 6, 0));
    exp_q.push_back(mk(2, 0, 6, 0));
    exp_q.push_back(mk(3, 0, 6, 0));
    for (int i = 0; i < 4; i++) read_main("t4_rec");
    wait_idle_main("t4_idle");
    tick();
    chk("t4_done_cnt", done_cnt, 32'd2);

    // Test 5: abort after one record; record survives, restart from coarse 0
    stop_therm = 64'h0000_0000_0000_0001;
    start = 1; tick(); start = 0;
    tick();
    stop_hit = 4'b0001; tick(); stop_hit = '0;
    tick();
    abort = 1; tick(); abort = 0;
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    tick(2);
    chk("t5_no_done", done_cnt, 32'd2);
    exp_q.push_back(mk(0, 0, 1, 1));
    read_main("t5_kept");
    stop_therm = {4{16'h0003}};
    start = 1; tick(); start = 0;
    stop_hit = 4'b1111; tick(); stop_hit = '0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, 0, 0, 2));
    for (int i = 0; i < 4; i++) read_main("t5_restart");
    wait_idle_main("t5_idle");
    tick();
    chk("t5_done_cnt", done_cnt, 32'd3);

    // Test 6: asynchronous reset mid-measurement
    stop_therm = {4{16'h0003}};
    start = 1; tick(); start = 0;
    tick();
    stop_hit = 4'b0001; tick(); stop_hit = '0;
    tick(2);
    chk("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_data", {12'd0, out_data}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    chk("t6_rst_full", {31'd0, fifo_full}, 32'd0);
    #3 rst = 1'b0;
    tick(2);
    chk("t6_post_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_post_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
